// File: rtl/owr_pkg.sv
// Shared types and constants for the 1-Wire DS18B20 responder and its master-side peers.
package owr_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_PRES_WAIT, S_PRES_DRV, S_ROM_CMD,
    S_TX_ROM, S_FUNC_CMD, S_CONV, S_TX_SCR
  } state_t;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_READ_ROM = 8'h33;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SCR = 8'hBE;

  // Fixed scratchpad bytes 2..7: TH, TL, config, reserved
  localparam logic [7:0] SCR_TH   = 8'h4B;
  localparam logic [7:0] SCR_TL   = 8'h46;
  localparam logic [7:0] SCR_CFG  = 8'h7F;
  localparam logic [7:0] SCR_RSV0 = 8'hFF;
  localparam logic [7:0] SCR_RSV1 = 8'h0C;
  localparam logic [7:0] SCR_RSV2 = 8'h10;

  localparam logic [7:0] CRC_POLY = 8'h8C;
endpackage

// File: rtl/owr_crc8.sv
// Bit-serial Dallas/Maxim CRC8 (x^8+x^5+x^4+1), data consumed LSB first.
module owr_crc8
  import owr_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  logic fb;
  assign fb = o_crc[0] ^ i_bit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_crc <= 8'h00;
    else if (i_clr) o_crc <= 8'h00;
    else if (i_en)  o_crc <= (o_crc >> 1) ^ (fb ? CRC_POLY : 8'h00);
  end
endmodule

// File: rtl/owr_ds18b20_slave.sv
// DS18B20 emulator on a 1-Wire bus: presence, Skip/Read ROM, Convert T, Read Scratchpad.
module owr_ds18b20_slave
  import owr_pkg::*;
#(
  parameter int          CLK_PER_US  = 48,
  parameter int          RST_MIN_US  = 400,
  parameter int          PRES_DLY_US = 30,
  parameter int          PRES_LEN_US = 120,
  parameter int          SAMPLE_US   = 30,
  parameter int          TX0_US      = 30,
  parameter int          CONV_US     = 750000,
  parameter logic [15:0] POR_TEMP    = 16'h0550,
  parameter logic [63:0] ROM_ID      = 64'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_owr,
  output logic        o_owr_pd,
  input  logic [15:0] i_temp,
  output logic        o_conv_busy,
  output logic        o_conv_stb,
  output logic [7:0]  o_cmd,
  output logic        o_cmd_stb
);
  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int UW = 10;
  localparam int CW = $clog2(CONV_US + 1);

  logic [2:0]    sync;
  logic          owr_s, fall, rise, fall_slot, rst_det;
  logic [PW-1:0] presc;
  logic          us_tick;
  logic [UW-1:0] us_cnt;
  state_t        state;
  logic [6:0]    bit_cnt;
  logic [6:0]    rx_sh;
  logic [7:0]    rx_byte;
  logic          slot_act, rx_pt, tx_pt, is_rx, is_tx, tx_bit;
  logic          pres_on, pres_off;
  logic [CW-1:0] conv_tmr;
  logic [15:0]   temp;
  logic [63:0]   scr;
  logic [7:0]    crc;
  logic          crc_en;

  // sync[1:0] is the synchronizer, sync[2] only remembers the previous synced level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= 3'b111;
    else          sync <= {sync[1:0], i_owr};
  end
  assign owr_s     = sync[1];
  assign fall      = sync[2] & ~sync[1];
  assign rise      = ~sync[2] & sync[1];
  assign fall_slot = fall & ~o_owr_pd;
  assign rst_det   = rise && (int'(us_cnt) >= RST_MIN_US);

  assign us_tick = (presc == PW'(CLK_PER_US - 1));
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     presc <= '0;
    else if (us_tick) presc <= '0;
    else              presc <= presc + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       us_cnt <= '0;
    else if (fall_slot || rst_det)      us_cnt <= '0;
    else if (us_tick && us_cnt != '1)   us_cnt <= us_cnt + 1'b1;
  end

  // Presence edges fire on the tick that completes the interval, not one cycle later
  assign pres_on  = us_tick && (int'(us_cnt) + 1 >= PRES_DLY_US);
  assign pres_off = us_tick && (int'(us_cnt) + 1 >= PRES_DLY_US + PRES_LEN_US);
  assign rx_pt    = slot_act && (int'(us_cnt) >= SAMPLE_US);
  assign tx_pt    = slot_act && (int'(us_cnt) >= TX0_US);
  assign is_rx    = (state == S_ROM_CMD) || (state == S_FUNC_CMD);
  assign is_tx    = (state == S_TX_ROM) || (state == S_TX_SCR) || (state == S_CONV);
  assign rx_byte  = {owr_s, rx_sh};

  assign scr = {SCR_RSV2, SCR_RSV1, SCR_RSV0, SCR_CFG, SCR_TL, SCR_TH, temp};

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      S_TX_ROM: tx_bit = ROM_ID[bit_cnt[5:0]];
      S_TX_SCR: tx_bit = (bit_cnt < 7'd64) ? scr[bit_cnt[5:0]] : crc[bit_cnt[2:0]];
      S_CONV:   tx_bit = ~o_conv_busy;
      default:  tx_bit = 1'b1;
    endcase
  end

  // CRC folds in each data bit as its slot completes; byte 8 is sent from the frozen result
  assign crc_en = (state == S_TX_SCR) && !rst_det && !fall_slot && tx_pt && (bit_cnt < 7'd64);

  owr_crc8 u_crc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (state != S_TX_SCR),
    .i_en    (crc_en),
    .i_bit   (tx_bit),
    .o_crc   (crc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      o_owr_pd    <= 1'b0;
      bit_cnt     <= '0;
      rx_sh       <= '0;
      slot_act    <= 1'b0;
      o_cmd       <= 8'h00;
      o_cmd_stb   <= 1'b0;
      o_conv_busy <= 1'b0;
      o_conv_stb  <= 1'b0;
      conv_tmr    <= '0;
      temp        <= POR_TEMP;
    end else begin
      o_cmd_stb  <= 1'b0;
      o_conv_stb <= 1'b0;

      if (o_conv_busy && us_tick) begin
        if (conv_tmr == CW'(1)) begin
          o_conv_busy <= 1'b0;
          o_conv_stb  <= 1'b1;
          temp        <= i_temp;
        end
        conv_tmr <= conv_tmr - 1'b1;
      end

      if (rst_det) begin
        state    <= S_PRES_WAIT;
        o_owr_pd <= 1'b0;
        bit_cnt  <= '0;
        slot_act <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_PRES_WAIT: if (pres_on) begin
            o_owr_pd <= 1'b1;
            state    <= S_PRES_DRV;
          end
          S_PRES_DRV: if (pres_off) begin
            o_owr_pd <= 1'b0;
            state    <= S_ROM_CMD;
          end
          default: begin
            if (fall_slot) begin
              slot_act <= 1'b1;
              if (is_tx && !tx_bit) o_owr_pd <= 1'b1;
            end else if (is_rx && rx_pt) begin
              slot_act <= 1'b0;
              rx_sh    <= rx_byte[7:1];
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == 7'd7) begin
                bit_cnt <= '0;
                if (state == S_ROM_CMD) begin
                  if (rx_byte == CMD_SKIP_ROM)      state <= S_FUNC_CMD;
                  else if (rx_byte == CMD_READ_ROM) state <= S_TX_ROM;
                  else                              state <= S_IDLE;
                end else begin
                  o_cmd     <= rx_byte;
                  o_cmd_stb <= 1'b1;
                  if (rx_byte == CMD_CONVERT) begin
                    o_conv_busy <= 1'b1;
                    conv_tmr    <= CW'(CONV_US);
                    state       <= S_CONV;
                  end else if (rx_byte == CMD_READ_SCR) begin
                    state <= S_TX_SCR;
                  end else begin
                    state <= S_IDLE;
                  end
                end
              end
            end else if (is_tx && tx_pt) begin
              slot_act <= 1'b0;
              o_owr_pd <= 1'b0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (state == S_TX_ROM && bit_cnt == 7'd63) begin
                bit_cnt <= '0;
                state   <= S_FUNC_CMD;
              end
              if (state == S_TX_SCR && bit_cnt == 7'd71) state <= S_IDLE;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_owr_ds18b20_slave.sv
// Directed bench for the DS18B20 responder: a bus master model drives slots, a scoreboard checks replies.
`timescale 1ns/1ps
module tb_owr_ds18b20_slave;
  localparam int          CPU = 2;
  localparam logic [63:0] ROM = 64'hB5_00_00_0A_1B_2C_3D_28;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        m_pd;
  logic        owr;
  logic        o_owr_pd;
  logic [15:0] i_temp;
  logic        o_conv_busy, o_conv_stb, o_cmd_stb;
  logic [7:0]  o_cmd;

  always #5 i_clk = ~i_clk;
  assign owr = ~(m_pd | o_owr_pd);

  owr_ds18b20_slave #(
    .CLK_PER_US (CPU),
    .CONV_US    (1000),
    .ROM_ID     (ROM)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_owr       (owr),
    .o_owr_pd    (o_owr_pd),
    .i_temp      (i_temp),
    .o_conv_busy (o_conv_busy),
    .o_conv_stb  (o_conv_stb),
    .o_cmd       (o_cmd),
    .o_cmd_stb   (o_cmd_stb)
  );

  int n_chk = 0, n_pass = 0, n_conv = 0, rd_n = 0;
  logic       rd_q[$];
  logic [7:0] cmd_q[$];
  logic       rd_stb = 1'b0, rd_val = 1'b0;
  logic [7:0] scr_por [9] = '{8'h50, 8'h05, 8'h4B, 8'h46, 8'h7F, 8'hFF, 8'h0C, 8'h10, 8'h1C};
  logic [63:0] rom_v;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask

  task automatic chk_rng(input string nm, input int v, input int lo, input int hi);
    n_chk++;
    if (v >= lo && v <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", nm, v, lo, hi);
  endtask

  // Read-bit scoreboard: bench-only strobe, sampled on posedge
  always @(posedge i_clk) if (rd_stb) begin
    if (rd_q.size() == 0) begin
      n_chk++;
      $display("FAIL rd_unexpected: got %0b, expected no read", rd_val);
    end else chk($sformatf("rd_bit%0d", rd_n), rd_val, rd_q.pop_front());
    rd_n++;
  end

  // DUT-output monitors, sampled away from the active edge
  always @(negedge i_clk) begin
    if (o_cmd_stb) begin
      if (cmd_q.size() == 0) begin
        n_chk++;
        $display("FAIL cmd_unexpected: got %0h, expected no command", o_cmd);
      end else chk("cmd", o_cmd, cmd_q.pop_front());
    end
    if (o_conv_stb) n_conv++;
  end

  task automatic wait_us(input int n);
    repeat (n * CPU) @(negedge i_clk);
  endtask

  task automatic write_bit(input logic b);
    m_pd = 1'b1;
    if (b) begin wait_us(6);  m_pd = 1'b0; wait_us(59); end
    else   begin wait_us(60); m_pd = 1'b0; wait_us(5);  end
  endtask

  task automatic write_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) write_bit(b[i]);
  endtask

  task automatic read_slot(output logic v);
    m_pd = 1'b1; wait_us(2);
    m_pd = 1'b0; wait_us(10);
    v = owr;     wait_us(53);
  endtask

  task automatic rd_exp(input logic e);
    logic v;
    rd_q.push_back(e);
    read_slot(v);
    rd_val = v; rd_stb = 1'b1;
    @(negedge i_clk) rd_stb = 1'b0;
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) rd_exp(b[i]);
  endtask

  task automatic bus_reset(input string nm);
    int t, l;
    m_pd = 1'b1; wait_us(480);
    m_pd = 1'b0;
    t = 0;
    while (!o_owr_pd && t < 60 * CPU) begin @(negedge i_clk); t++; end
    chk_rng({nm, "_pres_dly"}, t, 29 * CPU, 31 * CPU + 2);
    l = 0;
    while (o_owr_pd && l < 200 * CPU) begin @(negedge i_clk); l++; end
    chk_rng({nm, "_pres_len"}, l, 119 * CPU, 121 * CPU + 2);
    wait_us(10);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, seen;
    time  t0, ts;
    int   n;
    rom_v = ROM;
    i_rst_n = 1'b0; m_pd = 1'b0; i_temp = 16'h0550;
    repeat (4) @(negedge i_clk);
    chk("rst_pd",   o_owr_pd,    1'b0);
    chk("rst_busy", o_conv_busy, 1'b0);
    chk("rst_cstb", o_conv_stb,  1'b0);
    chk("rst_cmd",  o_cmd,       8'h00);
    chk("rst_stb",  o_cmd_stb,   1'b0);
    i_rst_n = 1'b1;
    wait_us(5);

    // Short low pulse while idle must not draw a presence pulse
    seen = 1'b0;
    m_pd = 1'b1;
    for (int i = 0; i < 100 * CPU; i++) begin @(negedge i_clk); seen |= o_owr_pd; end
    m_pd = 1'b0;
    for (int i = 0; i < 300 * CPU; i++) begin @(negedge i_clk); seen |= o_owr_pd; end
    chk("t2_no_pres", seen, 1'b0);

    // Power-on scratchpad dump, then released line
    bus_reset("t1");
    write_byte(8'hCC);
    cmd_q.push_back(8'hBE);
    write_byte(8'hBE);
    for (int i = 0; i < 9; i++) exp_byte(scr_por[i]);
    rd_exp(1'b1);

    // Reset mid-dump restarts the scratchpad from byte 0
    bus_reset("t5a");
    write_byte(8'hCC);
    cmd_q.push_back(8'hBE);
    write_byte(8'hBE);
    for (int i = 0; i < 20; i++) rd_exp(scr_por[i / 8][i % 8]);
    bus_reset("t5b");
    write_byte(8'hCC);
    cmd_q.push_back(8'hBE);
    write_byte(8'hBE);
    for (int i = 0; i < 9; i++) exp_byte(scr_por[i]);

    // Unknown ROM command silences the device; Read ROM returns the ID
    bus_reset("t6a");
    write_byte(8'h55);
    for (int i = 0; i < 8; i++) rd_exp(1'b1);
    bus_reset("t6b");
    write_byte(8'h33);
    for (int i = 0; i < 64; i++) rd_exp(rom_v[i]);

    // Conversion: busy reads 0 until ~1000 us after the command, then latched temperature
    i_temp = 16'h0191;
    bus_reset("t4a");
    write_byte(8'hCC);
    cmd_q.push_back(8'h44);
    write_byte(8'h44);
    t0 = $time;
    chk("t4_busy", o_conv_busy, 1'b1);
    read_slot(v);
    chk("t4_first_rd", v, 1'b0);
    n = 0; ts = t0;
    while (!v && n < 40) begin
      ts = $time;
      read_slot(v);
      n++;
    end
    chk_rng("t4_done_us", int'((ts - t0) / (10 * CPU)), 963, 1032);
    chk("t4_busy_clr", o_conv_busy, 1'b0);
    chk("t4_conv_stb", n_conv, 1);
    bus_reset("t4b");
    write_byte(8'hCC);
    cmd_q.push_back(8'hBE);
    write_byte(8'hBE);
    exp_byte(8'h91);
    exp_byte(8'h01);
    wait_us(5);

    chk("conv_stb_total", n_conv, 1);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/owr_ds18b20_slave.md
Name: owr_ds18b20_slave

Overview:
- 1-Wire responder that emulates a DS18B20 temperature sensor on the bus; it is the far end of the bus driven by the ds18b20 master and read_temp sequencer.
- Used as a loop-back target in simulation and on the board, so the master path can be exercised without a real sensor.
- Decodes reset/presence, write slots and read slots in normal-speed mode.
- Supports ROM commands CCh (Skip ROM) and 33h (Read ROM), and function commands 44h (Convert T) and BEh (Read Scratchpad), with a CRC8-protected scratchpad.

Parameters:
CLK_PER_US, 48, clock cycles per microsecond (µs tick prescaler)
RST_MIN_US, 400, minimum low time in µs that counts as a bus reset
PRES_DLY_US, 30, delay in µs from reset release to the start of the presence pulse
PRES_LEN_US, 120, presence pulse low time in µs
SAMPLE_US, 30, write-slot sample point in µs after the falling edge
TX0_US, 30, hold-low time in µs when transmitting a 0
CONV_US, 750000, conversion duration in µs (testbenches override it small)
POR_TEMP, 16'h0550, scratchpad temperature value after reset (85 °C)
ROM_ID, 64'h..., 64-bit ROM code returned for 33h, sent LSB first; user supplies a valid CRC in it

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_owr  in  1  1-Wire line sense, asynchronous to i_clk
o_owr_pd  out  1  1 = pull the line low (open-drain enable)
i_temp  in  16  live temperature, DS18B20 format, sampled when a conversion ends
o_conv_busy  out  1  conversion in progress
o_conv_stb  out  1  one-cycle pulse when i_temp is latched into the scratchpad
o_cmd  out  8  last decoded function command
o_cmd_stb  out  1  one-cycle pulse when o_cmd updates

Behaviour:
- Reset values: o_owr_pd=0, o_conv_busy=0, o_conv_stb=0, o_cmd=00h, o_cmd_stb=0, temperature register=POR_TEMP, state=S_IDLE.
- i_owr passes through a 2-flop synchronizer; all edges are measured on the synced signal, giving 2 cycles of latency.
- A prescaler generates a 1-cycle µs tick. A saturating µs counter clears on each falling edge and counts low/high time.
- Reset detect, in any state: a rising edge with low time ≥ RST_MIN_US aborts the current operation and enters S_PRES_WAIT. The bit counter and CRC clear. The conversion timer is NOT affected.
- States:
  - S_IDLE: ignore slots; wait for reset.
  - S_PRES_WAIT: after PRES_DLY_US → S_PRES_DRV.
  - S_PRES_DRV: o_owr_pd=1 for PRES_LEN_US → S_ROM_CMD.
  - S_ROM_CMD: receive 8 bits. CCh → S_FUNC_CMD. 33h → S_TX_ROM. Any other value → S_IDLE.
  - S_TX_ROM: send 64 bits of ROM_ID → S_FUNC_CMD.
  - S_FUNC_CMD: receive 8 bits, then pulse o_cmd_stb and set o_cmd. 44h → start conversion, go to S_CONV. BEh → S_TX_SCR. Any other value → S_IDLE.
  - S_CONV: each read slot returns ~o_conv_busy.
  - S_TX_SCR: send 72 bits, then → S_IDLE. Read slots after that see a released line (1).
- Write slot (receive): sample the line at SAMPLE_US after the falling edge; low → bit 0, high → bit 1. Bits arrive LSB first. A slot whose low time ends before SAMPLE_US reads as 1.
- Read slot (transmit): on the falling edge, if the current bit is 0, assert o_owr_pd for TX0_US. If it is 1, do not drive. The bit pointer advances at the end of each slot.
- Scratchpad, in transmit order:
  - byte 0: temperature LSB; byte 1: temperature MSB
  - byte 2: 4Bh; byte 3: 46h; byte 4: 7Fh; byte 5: FFh; byte 6: 0Ch; byte 7: 10h
  - byte 8: CRC8 (poly x^8+x^5+x^4+1, LSB first, init 00h) over bytes 0–7, updated as each bit is sent.
- Conversion:
  - On 44h: o_conv_busy=1 and a µs timer loads CONV_US.
  - At expiry: latch i_temp, pulse o_conv_stb, clear o_conv_busy.
  - 44h received while busy restarts the timer.
  - BEh received during a conversion returns the old temperature.
- A falling edge that arrives while o_owr_pd is asserted (presence or TX0) is ignored as a slot start.

Decomposition:
- Package owr_pkg:
  - state enum
  - command constants CCh, 33h, 44h, BEh
  - scratchpad constant bytes 4Bh, 46h, 7Fh, FFh, 0Ch, 10h
  - CRC polynomial 8Ch (reflected)
- Sub-module owr_crc8: bit-serial Dallas CRC with clear, enable and data-bit inputs and an 8-bit output. The master side can reuse it.

Test Plan:
1. Line low 480 µs, then released → o_owr_pd high from 30 µs to 150 µs after release (±1 µs plus 2 cycles).
2. Line low 100 µs while in S_IDLE → no presence pulse; o_owr_pd stays 0.
3. Reset, write CCh, write BEh, 72 read slots before any convert → bytes 50 05 4B 46 7F FF 0C 10 1C; the 73rd read slot returns 1.
4. CONV_US=1000, i_temp=0191h; reset, CCh, 44h → o_cmd=44h, and read slots return 0 until 1000 µs then 1. o_conv_stb pulses once. A following reset, CCh, BEh gives first two bytes 91 01.
5. Reset issued after 20 bits of BEh data → presence pulse, then CCh accepted and the scratchpad restarts at byte 0 with correct CRC.
6. ROM command 55h → no drive on any slot until the next reset. Reset, then 33h → 64 read slots equal ROM_ID LSB first.
